motor_cmd_scheduler: RTL

//  Sits between the balance-loop command source and motor_controller. It accepts signed speed

---
 rtl/motor_pkg.sv | 41 ++++
 rtl/motor_ramp_step.sv | 42 ++++
 rtl/motor_cmd_scheduler.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/motor_pkg.sv
// Shared types and helpers for the motor command scheduler.
//
// Contents:
//   MAG_W / CMD_W   widths of a motor duty magnitude and of a signed speed command
//   sched_state_t   scheduler FSM states (idle, compute step, present load)
//   motor_cmd_t     sign/magnitude pair as presented to motor_controller
//   cmd_to_target   converts a two's complement command into a clamped sign/magnitude target
package motor_pkg;

  localparam int unsigned MAG_W = 7;
  localparam int unsigned CMD_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStep,
    StLoad
  } sched_state_t;

  typedef struct packed {
    logic             sign;  // 1 = negative direction
    logic [MAG_W-1:0] mag;
  } motor_cmd_t;

  // -128 has no positive counterpart in 8 bits; its unsigned magnitude is 128, which the
  // clamp then brings down to max_mag. A zero command carries no direction, so the previous
  // target sign is kept to avoid a pointless sign flip through zero.
  function automatic motor_cmd_t cmd_to_target(input logic [CMD_W-1:0] cmd,
                                               input logic             prev_sign,
                                               input logic [CMD_W-1:0] max_mag);
    motor_cmd_t       tgt;
    logic [CMD_W-1:0] abs_val;
    abs_val  = cmd[CMD_W-1] ? (~cmd + CMD_W'(1)) : cmd;
    if (abs_val > max_mag) begin
      abs_val = max_mag;
    end
    tgt.mag  = abs_val[MAG_W-1:0];
    tgt.sign = (cmd == '0) ? prev_sign : cmd[CMD_W-1];
    return tgt;
  endfunction

endpackage

// File: rtl/motor_ramp_step.sv
// One slew-limited ramp step for a single motor (purely combinational).
//
// Ports:
//   cur_i      current sign/magnitude driven to the motor
//   tgt_i      effective target sign/magnitude
//   nxt_o      value the motor should take on this ramp tick
//   changed_o  nxt_o differs from cur_i
//
// A direction reversal is never done in one go: the magnitude first ramps down to zero with
// the old sign, then a tick flips only the sign, then the magnitude ramps up again.
module motor_ramp_step
  import motor_pkg::*;
#(
  parameter int unsigned STEP = 4
) (
  input  motor_cmd_t cur_i,
  input  motor_cmd_t tgt_i,
  output motor_cmd_t nxt_o,
  output logic       changed_o
);

  localparam logic [MAG_W-1:0] StepMag = MAG_W'(STEP);

  always_comb begin
    nxt_o = cur_i;
    if (cur_i.sign != tgt_i.sign) begin
      if (cur_i.mag != '0) begin
        nxt_o.mag = (cur_i.mag > StepMag) ? (cur_i.mag - StepMag) : '0;
      end else begin
        nxt_o.sign = tgt_i.sign;
      end
    end else if (cur_i.mag < tgt_i.mag) begin
      // Clip to the target so a partial final step never overshoots.
      nxt_o.mag = ((tgt_i.mag - cur_i.mag) > StepMag) ? (cur_i.mag + StepMag) : tgt_i.mag;
    end else if (cur_i.mag > tgt_i.mag) begin
      nxt_o.mag = ((cur_i.mag - tgt_i.mag) > StepMag) ? (cur_i.mag - StepMag) : tgt_i.mag;
    end
  end

  assign changed_o = (nxt_o != cur_i);

endmodule

// File: rtl/motor_cmd_scheduler.sv
// Slew-limiting command scheduler between the balance loop and motor_controller.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; accepted when both are high
//   cmd_m1, cmd_m2        signed (two's complement) speed commands per motor
//   arm                   low forces both effective targets to zero
//   load                  one-cycle strobe: motor outputs just changed, latch them
//   motorN_sign           1 = negative direction
//   motorN_upperlimit     duty magnitude
//   timeout               watchdog expired, targets forced to zero
//
// Every RAMP_DIV cycles a tick moves each motor at most STEP toward its target. A tick that
// changes either motor produces STEP -> LOAD; otherwise the FSM stays quiet, so load is never
// raised with unchanged outputs. Commands are only taken in IDLE, which keeps the target
// stable across the STEP/LOAD pair.
module motor_cmd_scheduler
  import motor_pkg::*;
#(
  parameter int unsigned RAMP_DIV = 1000,    // cycles between ramp ticks, >= 4
  parameter int unsigned STEP     = 4,       // max magnitude change per tick (1..127)
  parameter int unsigned MAX_MAG  = 100,     // magnitude clamp (<= 127)
  parameter int unsigned WDOG_CYC = 5000000  // cycles without an accept before failsafe
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CMD_W-1:0] cmd_m1,
  input  logic [CMD_W-1:0] cmd_m2,
  input  logic             arm,
  output logic             load,
  output logic             motor1_sign,
  output logic [MAG_W-1:0] motor1_upperlimit,
  output logic             motor2_sign,
  output logic [MAG_W-1:0] motor2_upperlimit,
  output logic             timeout
);

  localparam int unsigned PreW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned WdW  = $clog2(WDOG_CYC + 1);

  localparam logic [PreW-1:0]  PreLast = PreW'(RAMP_DIV - 1);
  localparam logic [WdW-1:0]   WdMax   = WdW'(WDOG_CYC);
  localparam logic [CMD_W-1:0] MaxMag  = CMD_W'(MAX_MAG);

  sched_state_t   state_q, state_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic [WdW-1:0]  wdog_q, wdog_d;
  motor_cmd_t     tgt1_q, tgt1_d;
  motor_cmd_t     tgt2_q, tgt2_d;
  motor_cmd_t     out1_q, out1_d;
  motor_cmd_t     out2_q, out2_d;

  logic       accept;
  logic       tick;
  logic       force_zero;
  motor_cmd_t eff1, eff2;
  motor_cmd_t nxt1, nxt2;
  logic       chg1, chg2;

  assign cmd_ready = (state_q == StIdle) & ~reset;
  assign accept    = cmd_valid & cmd_ready;
  assign tick      = (pre_q == PreLast);
  assign timeout   = (wdog_q == WdMax);

  // Forced-zero targets borrow the current output sign so that a failsafe or disarm ramps
  // the magnitude down without also flipping direction at the bottom.
  assign force_zero = ~arm | timeout;
  assign eff1       = force_zero ? '{sign: out1_q.sign, mag: '0} : tgt1_q;
  assign eff2       = force_zero ? '{sign: out2_q.sign, mag: '0} : tgt2_q;

  motor_ramp_step #(
    .STEP (STEP)
  ) u_ramp_m1 (
    .cur_i     (out1_q),
    .tgt_i     (eff1),
    .nxt_o     (nxt1),
    .changed_o (chg1)
  );

  motor_ramp_step #(
    .STEP (STEP)
  ) u_ramp_m2 (
    .cur_i     (out2_q),
    .tgt_i     (eff2),
    .nxt_o     (nxt2),
    .changed_o (chg2)
  );

  // Free-running prescaler; tick marks the last count before the wrap to zero.
  always_comb begin
    pre_d = tick ? '0 : (pre_q + PreW'(1));
  end

  // Watchdog saturates instead of wrapping so timeout stays asserted until a new accept.
  always_comb begin
    wdog_d = wdog_q;
    if (accept) begin
      wdog_d = '0;
    end else if (wdog_q != WdMax) begin
      wdog_d = wdog_q + WdW'(1);
    end
  end

  always_comb begin
    tgt1_d = tgt1_q;
    tgt2_d = tgt2_q;
    if (accept) begin
      tgt1_d = cmd_to_target(cmd_m1, tgt1_q.sign, MaxMag);
      tgt2_d = cmd_to_target(cmd_m2, tgt2_q.sign, MaxMag);
    end
  end

  always_comb begin
    state_d = state_q;
    out1_d  = out1_q;
    out2_d  = out2_q;
    case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StStep;
        end
      end
      StStep: begin
        if (chg1 || chg2) begin
          state_d = StLoad;
          out1_d  = nxt1;
          out2_d  = nxt2;
        end else begin
          state_d = StIdle;
        end
      end
      StLoad: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pre_q   <= '0;
      wdog_q  <= '0;
      tgt1_q  <= '0;
      tgt2_q  <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      wdog_q  <= wdog_d;
      tgt1_q  <= tgt1_d;
      tgt2_q  <= tgt2_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
    end
  end

  assign load              = (state_q == StLoad);
  assign motor1_sign       = out1_q.sign;
  assign motor1_upperlimit = out1_q.mag;
  assign motor2_sign       = out2_q.sign;
  assign motor2_upperlimit = out2_q.mag;

endmodule
